// File: rtl/dffsre_pkg.sv
`default_nettype none
// ============================================================================
// dffsre_pkg : shared helpers and parameter checks for the dffsre lane bank
// Revision   : 1.0
// ============================================================================

package dffsre_pkg;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

`define DFFSRE_ELAB_CHECK(LABEL, COND) \
    if (!(COND)) begin : LABEL \
        $error("dffsre parameter check failed"); \
    end

`default_nettype wire

// File: rtl/dffsre_pipe_lane.sv
`default_nettype none
// ============================================================================
// dffsre_pipe_lane : one WIDTH x DEPTH enable-gated shift chain with set,
//                    saturating fill counter and registered primed flag
// Revision         : 1.0
// ============================================================================

module dffsre_pipe_lane
    import dffsre_pkg::*;
#(
    parameter int WIDTH   = 1,
    parameter int DEPTH   = 1,
    parameter int SET_VAL = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_set,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q,
    output logic             o_primed
);

    localparam int               FW       = clog2_min1(DEPTH + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(DEPTH);
    // A set value of 1 means "all ones" regardless of lane width.
    localparam logic [WIDTH-1:0] SET_WORD = (SET_VAL == 1) ? {WIDTH{1'b1}} : WIDTH'(SET_VAL);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             primed_q;
    logic             primed_d;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            stage_d[k] = stage_q[k];
        end
        fill_d = fill_q;
        if (i_set) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = SET_WORD;
            end
            fill_d = FILL_MAX;
        end else if (i_en) begin
            stage_d[0] = i_d;
            for (int k = 1; k < DEPTH; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != FILL_MAX) begin
                fill_d = fill_q + FW'(1);
            end
        end
        primed_d = (fill_d == FILL_MAX);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
            fill_q   <= '0;
            primed_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= stage_d[k];
            end
            fill_q   <= fill_d;
            primed_q <= primed_d;
        end
    end

    assign o_q      = stage_q[DEPTH-1];
    assign o_primed = primed_q;

endmodule

`default_nettype wire

// File: rtl/dffsre_pipe_bank.sv
`default_nettype none
// ============================================================================
// dffsre_pipe_bank : NCH independent dffsre pipeline lanes with shared set
//                    and sel-gated (combinational or registered) outputs
// Revision         : 1.0
// ============================================================================

module dffsre_pipe_bank
    import dffsre_pkg::*;
#(
    parameter int WIDTH    = 1,
    parameter int NCH      = 8,
    parameter int DEPTH    = 1,
    parameter int SET_VAL  = 1,
    parameter int GATE_REG = 0
) (
    input  logic                 C,
    input  logic                 R,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [NCH-1:0]       E,
    input  logic                 S,
    input  logic                 sel,
    output logic [NCH*WIDTH-1:0] Q,
    output logic [NCH*WIDTH-1:0] Q_out,
    output logic [NCH-1:0]       primed
);

    `DFFSRE_ELAB_CHECK(g_chk_width, WIDTH >= 1)
    `DFFSRE_ELAB_CHECK(g_chk_nch,   NCH >= 1)
    `DFFSRE_ELAB_CHECK(g_chk_depth, DEPTH >= 1)

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        dffsre_pipe_lane #(
            .WIDTH   (WIDTH),
            .DEPTH   (DEPTH),
            .SET_VAL (SET_VAL)
        ) u_lane (
            .i_clk    (C),
            .i_rst_n  (R),
            .i_en     (E[i]),
            .i_set    (S),
            .i_d      (D[i*WIDTH +: WIDTH]),
            .o_q      (Q[i*WIDTH +: WIDTH]),
            .o_primed (primed[i])
        );
    end

    if (GATE_REG != 0) begin : g_gate_reg
        logic [NCH*WIDTH-1:0] qout_q;
        logic [NCH*WIDTH-1:0] qout_d;

        // Samples the currently visible Q, so the gated copy trails Q by one edge.
        always_comb begin
            qout_d = sel ? Q : '0;
        end

        always_ff @(posedge C or negedge R) begin
            if (!R) begin
                qout_q <= '0;
            end else begin
                qout_q <= qout_d;
            end
        end

        assign Q_out = qout_q;
    end else begin : g_gate_comb
        assign Q_out = sel ? Q : '0;
    end

endmodule

`default_nettype wire
